sar_seq_ctrl: RTL and testbench
===============================

Name: sar_seq_ctrl

Overview:
- Synchronous digital sequencer for the 8-bit SAR ADC in the TT06 SAR tile.
- Replaces the clock-edge-driven OFF/SAMPLE/CONVERT/DONE sequencing with a clean single-clock FSM.
- Drives the sampling switch and the trial DAC code, and samples the comparator MSB-first.
- Publishes each result through a valid/ready output register to the uo_out/uio logic.

Parameters:
NBITS, 8, resolution; trial-code and result width.
SAMPLE_CYC, 2, cycles sample_o is held high per conversion (>=1).
SETTLE_CYC, 1, cycles each trial DAC code is held before the comparator is captured (>=1).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  block enable (ui_in[0]); low = synchronous abort to IDLE.
start  input  1  conversion request, level-sampled in IDLE.
cont  input  1  1 = free-running back-to-back conversions, 0 = single shot.
cmp  input  1  comparator output; 1 = vin >= DAC trial code.
sample_o  output  1  sampling switch control, high during SAMPLE.
dac_o  output  NBITS  trial code to the capacitive DAC.
busy  output  1  high in SAMPLE, CONVERT and DONE.
dout  output  NBITS  last completed conversion result.
dout_valid  output  1  dout holds an unconsumed result.
dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
overrun  output  1  sticky: a result was overwritten before it was consumed.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset (rst=1 at an edge) clears everything: state=IDLE; sample_o, busy, dout_valid and overrun = 0; dac_o, dout and the internal result register = 0. rst has priority over en.
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE -> SAMPLE when en & start. start is ignored when en=0 or in any other state.
- SAMPLE: sample_o=1 and dac_o=0 for exactly SAMPLE_CYC cycles. Then clear the result register, set bit index i=NBITS-1, go to CONVERT.
- CONVERT, per bit i from MSB to LSB:
  - dac_o = result | (1<<i), held SETTLE_CYC cycles.
  - cmp is captured on the last of those cycles: cmp=1 keeps bit i, cmp=0 leaves it 0.
  - After bit 0 resolves, go to DONE.
- DONE (1 cycle): load dout <= result, set dout_valid=1. Next state is SAMPLE if cont & en, else IDLE.
- Latency: start seen high at edge k -> dout_valid high after edge k+SAMPLE_CYC+NBITS*SETTLE_CYC+1. Default: 11 cycles.
- Handshake:
  - dout_valid falls on the edge where dout_valid & dout_ready.
  - dout is stable while dout_valid=1 unless overrun occurs.
- Overrun:
  - DONE while dout_valid=1 and the handshake is not completing that same edge: dout is overwritten, dout_valid stays 1, overrun sets to 1.
  - Simultaneous handshake and DONE: new result loaded, dout_valid stays 1, no overrun.
  - overrun clears only on rst or en=0.
- en=0 at any edge: abort to IDLE. sample_o, dac_o, busy and overrun are cleared; dout_valid is cleared; dout holds its value. A partial result is never published.
- cont deasserted mid-conversion: the current conversion completes, then the FSM returns to IDLE.
- Outputs sample_o, dac_o and busy are registered (no combinational path from inputs).

Optional Feature:
- SAR_AVG_EN defined:
  - Each published result is the average of 4 consecutive conversions, accumulated in an (NBITS+2)-bit accumulator; dout = acc[NBITS+1:2], truncated.
  - A single start triggers 4 back-to-back conversions; DONE of conversions 1-3 goes straight to SAMPLE.
  - dout_valid/overrun are updated only on the 4th DONE.
  - en=0 clears the accumulator and the conversion count.
  - Single-shot latency = 4*(SAMPLE_CYC+NBITS*SETTLE_CYC+1) cycles (44 at defaults).
- SAR_AVG_EN undefined: every conversion is published as above; no accumulator logic.

Test Plan:
1. Reset: rst=1 for 2 cycles with en=1, start=1 -> all outputs 0; after release, busy rises the edge after start is seen.
2. Single shot, model cmp=(0xA5>=dac_o), start pulse at edge 0 -> sample_o high cycles 1-2; dac_o = 80,C0,A0,B0,A8,A4,A6,A5; dout=0xA5 with dout_valid after edge 11; busy low after that DONE.
3. Extremes: vin=0x00 -> dac_o sequence 80,40,20,...,01, dout=0x00; vin=0xFF -> dout=0xFF.
4. cont=1, dout_ready=0, vin=0x3C then 0x71 -> first dout=0x3C; at second DONE dout=0x71, overrun=1, dout_valid=1. Pulse en=0 -> overrun=0, dout_valid=0, dout=0x71.
5. Abort: en dropped during bit 4 trial -> next cycle IDLE, dac_o=0, no dout_valid. Re-enable and start with vin=0x5A -> dout=0x5A.
6. SETTLE_CYC=3, vin=0xC3 -> each dac_o value held exactly 3 cycles; dout=0xC3 valid 27 cycles after start; handshake with dout_ready=1 drops dout_valid the same edge.

Source files
------------

// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl: single-clock sequencer for an NBITS SAR ADC (sample, MSB-first search, publish).
// Ports: clk/rst (sync, active-high); en/start/cont control; cmp from the comparator;
//    sample_o/dac_o/busy to the analog tile; dout/dout_valid/dout_ready result handshake;
//    overrun sticky flag. Latency start->dout_valid = SAMPLE_CYC+NBITS*SETTLE_CYC+1.
// Optional macro SAR_AVG_EN: publish the truncated mean of 4 back-to-back conversions per start.
module sar_seq_ctrl #(
   parameter int NBITS      = 8,
   parameter int SAMPLE_CYC = 2,
   parameter int SETTLE_CYC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             cont,
   input  logic             cmp,
   output logic             sample_o,
   output logic [NBITS-1:0] dac_o,
   output logic             busy,
   output logic [NBITS-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun
);

   localparam int CMAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int BW   = (NBITS > 1) ? $clog2(NBITS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;       // cycles spent in SAMPLE / on the current trial code
   logic [BW-1:0]    bit_q, bit_d;       // bit currently under trial
   logic [NBITS-1:0] res_q, res_d;       // bits resolved so far
   logic             sample_q, sample_d;
   logic [NBITS-1:0] dac_q, dac_d;
   logic             busy_q, busy_d;
   logic [NBITS-1:0] dout_q, dout_d;
   logic             vld_q, vld_d;
   logic             ovr_q, ovr_d;
   logic [NBITS-1:0] trial_bit;

`ifdef SAR_AVG_EN
   logic [NBITS+1:0] acc_q, acc_d;
   logic [1:0]       avg_cnt_q, avg_cnt_d;
   logic [NBITS+1:0] acc_sum;

   assign acc_sum = acc_q + (NBITS+2)'(res_q);
`endif

   assign trial_bit = NBITS'(1) << bit_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      res_d   = res_q;
      dout_d  = dout_q;
      vld_d   = vld_q;
      ovr_d   = ovr_q;
`ifdef SAR_AVG_EN
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
`endif
      if (!en) begin
         // Abort: partial results are dropped, published result value is kept.
         state_d = S_IDLE;
         cnt_d   = '0;
         vld_d   = 1'b0;
         ovr_d   = 1'b0;
`ifdef SAR_AVG_EN
         acc_d     = '0;
         avg_cnt_d = '0;
`endif
      end else begin
         if (vld_q && dout_ready) vld_d = 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_SAMPLE;
                  cnt_d   = '0;
               end
            end
            S_SAMPLE: begin
               if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
                  state_d = S_CONVERT;
                  cnt_d   = '0;
                  res_d   = '0;
                  bit_d   = BW'(NBITS - 1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_CONVERT: begin
               // Comparator is captured on the last settle cycle of each trial code.
               if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                  cnt_d = '0;
                  if (cmp) res_d = res_q | trial_bit;
                  if (bit_q == '0) state_d = S_DONE;
                  else             bit_d   = bit_q - BW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               cnt_d = '0;
`ifdef SAR_AVG_EN
               if (avg_cnt_q == 2'd3) begin
                  dout_d    = acc_sum[NBITS+1:2];
                  vld_d     = 1'b1;
                  if (vld_q && !dout_ready) ovr_d = 1'b1;
                  acc_d     = '0;
                  avg_cnt_d = '0;
                  state_d   = cont ? S_SAMPLE : S_IDLE;
               end else begin
                  acc_d     = acc_sum;
                  avg_cnt_d = avg_cnt_q + 2'd1;
                  state_d   = S_SAMPLE;
               end
`else
               dout_d  = res_q;
               vld_d   = 1'b1;
               // A result landing on an unconsumed one loses it, unless it is taken this edge.
               if (vld_q && !dout_ready) ovr_d = 1'b1;
               state_d = cont ? S_SAMPLE : S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
      // Analog controls are decoded from the next state so they leave a flop.
      sample_d = (state_d == S_SAMPLE);
      busy_d   = (state_d != S_IDLE);
      dac_d    = (state_d == S_CONVERT) ? (res_d | (NBITS'(1) << bit_d)) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         res_q    <= '0;
         sample_q <= 1'b0;
         dac_q    <= '0;
         busy_q   <= 1'b0;
         dout_q   <= '0;
         vld_q    <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef SAR_AVG_EN
         acc_q     <= '0;
         avg_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         res_q    <= res_d;
         sample_q <= sample_d;
         dac_q    <= dac_d;
         busy_q   <= busy_d;
         dout_q   <= dout_d;
         vld_q    <= vld_d;
         ovr_q    <= ovr_d;
`ifdef SAR_AVG_EN
         acc_q     <= acc_d;
         avg_cnt_q <= avg_cnt_d;
`endif
      end
   end

   assign sample_o   = sample_q;
   assign dac_o      = dac_q;
   assign busy       = busy_q;
   assign dout       = dout_q;
   assign dout_valid = vld_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// tb_sar_seq_ctrl: random + directed stimulus for sar_seq_ctrl with an ideal comparator.
// The driver predicts each conversion's publish edge and pushes it to a queue; the monitor
// tracks the output register from handshake rules and checks every cycle.
module tb_sar_seq_ctrl;

   localparam int NB  = 8;
   localparam int SMP = 2;
   localparam int STL = 1;
   localparam int L   = SMP + NB * STL + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1, en = 1'b1, start = 1'b1, cont = 1'b0, dout_ready = 1'b0;
   logic [NB-1:0] vin = '0;
   logic          cmp, sample_o, busy, dout_valid, overrun;
   logic [NB-1:0] dac_o, dout;

   // second instance with a 3-cycle settle time
   logic          en3 = 1'b0, start3 = 1'b0, ready3 = 1'b0;
   logic          cmp3, sample3, busy3, vld3, ovr3;
   logic [NB-1:0] dac3, dout3;

   always #5 clk = ~clk;

   assign cmp  = (vin >= dac_o);
   assign cmp3 = (8'hC3 >= dac3);

   sar_seq_ctrl #(.NBITS(NB), .SAMPLE_CYC(SMP), .SETTLE_CYC(STL)) u_dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont), .cmp(cmp),
      .sample_o(sample_o), .dac_o(dac_o), .busy(busy), .dout(dout),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .overrun(overrun));

   sar_seq_ctrl #(.NBITS(NB), .SAMPLE_CYC(SMP), .SETTLE_CYC(3)) u_s3 (
      .clk(clk), .rst(rst), .en(en3), .start(start3), .cont(1'b0), .cmp(cmp3),
      .sample_o(sample3), .dac_o(dac3), .busy(busy3), .dout(dout3),
      .dout_valid(vld3), .dout_ready(ready3), .overrun(ovr3));

   typedef struct {
      int            edge_n;
      logic [NB-1:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_tests = 0, n_fail = 0;

   // conversion model (driver side): state after the most recent edge
   logic          m_conv = 1'b0;
   int            m_start = 0, m_pub = 0, m_idle_from = 0;
   logic [NB-1:0] m_vin = '0;
   // output-register model (monitor side)
   logic          m_vld = 1'b0, m_ovr = 1'b0;
   logic [NB-1:0] m_dout = '0;

   // Ideal SAR trial code while testing bit i for input v: higher bits resolved, bit i set.
   function automatic logic [NB-1:0] trial(input logic [NB-1:0] v, input int i);
      int x;
      x = ((int'(v) >> (i + 1)) << (i + 1)) | (1 << i);
      return NB'(x);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
      end
   endtask

   // Drive inputs for the next edge and advance the conversion model across that edge.
   // v becomes the analog input only when a conversion begins at that edge.
   task automatic step(input logic r, input logic e_n, input logic s, input logic c,
                       input logic rdy, input logic [NB-1:0] v);
      int e;
      @(negedge clk);
      e = cyc + 1;
      rst = r; en = e_n; start = s; cont = c; dout_ready = rdy;
      if (r || !e_n) begin
         m_conv      = 1'b0;
         m_idle_from = e + 1;
         exp_q.delete();
      end else if (m_conv && e == m_pub) begin
         if (c) begin
            m_start = e; m_pub = e + L; m_vin = v; vin = v;
            exp_q.push_back('{edge_n: e + L, val: v});
         end else begin
            m_conv      = 1'b0;
            m_idle_from = e + 1;
         end
      end else if (!m_conv && e >= m_idle_from && s) begin
         m_conv = 1'b1; m_start = e; m_pub = e + L; m_vin = v; vin = v;
         exp_q.push_back('{edge_n: e + L, val: v});
      end
   endtask

   task automatic run(input int n, input logic rdy);
      for (int j = 0; j < n; j++) step(1'b0, 1'b1, 1'b0, 1'b0, rdy, 8'h00);
   endtask

   // Monitor / scoreboard
   always @(posedge clk) begin
      logic hs;
      int   t, i;
      cyc = cyc + 1;
      if (rst) begin
         m_vld = 1'b0; m_ovr = 1'b0; m_dout = '0;
      end else if (!en) begin
         m_vld = 1'b0; m_ovr = 1'b0;
      end else begin
         hs = m_vld & dout_ready;
         if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
            m_dout = exp_q[0].val;
            void'(exp_q.pop_front());
            if (m_vld && !hs) m_ovr = 1'b1;
            m_vld = 1'b1;
         end else if (hs) begin
            m_vld = 1'b0;
         end
      end
      #1;
      chk("dout_valid", 32'(dout_valid), 32'(m_vld));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("dout", 32'(dout), 32'(m_dout));
      chk("busy", 32'(busy), 32'(m_conv));
      if (m_conv) begin
         t = cyc - m_start;
         chk("sample_o", 32'(sample_o), 32'(t < SMP));
         if (t < SMP) begin
            chk("dac_o_sample", 32'(dac_o), 32'(0));
         end else if (t < SMP + NB * STL) begin
            i = NB - 1 - (t - SMP) / STL;
            chk("dac_o_trial", 32'(dac_o), 32'(trial(m_vin, i)));
         end
      end else begin
         chk("sample_o_idle", 32'(sample_o), 32'(0));
         chk("dac_o_idle", 32'(dac_o), 32'(0));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, t;
      logic seen, cont_r;

      // 1. reset held with en/start high, then start seen right after release
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      // 2. single shot 0xA5
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
      run(14, 1'b1);
      // 3. extremes
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      run(13, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
      run(13, 1'b1);
      // 4. continuous, consumer stalled: second result overruns; cont dropped mid-conversion
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C);
      for (int j = 0; j < 11; j++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h71);
      for (int j = 0; j < 13; j++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      run(3, 1'b0);
      // 5. abort during the bit-4 trial, then a clean conversion
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
      for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      run(3, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A);
      run(14, 1'b1);

      // 6. SETTLE_CYC=3 instance, vin=0xC3
      @(negedge clk);
      en3 = 1'b1; start3 = 1'b1; k = cyc + 1;
      @(negedge clk);
      start3 = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < 60 && !seen; j++) begin
         @(posedge clk);
         #1;
         t = cyc - k;
         if (t >= SMP && t < SMP + NB * 3)
            chk("s3_dac_hold", 32'(dac3), 32'(trial(8'hC3, NB - 1 - (t - SMP) / 3)));
         if (t <= SMP + NB * 3) chk("s3_sample_o", 32'(sample3), 32'(t < SMP));
         if (vld3) begin
            seen = 1'b1;
            chk("s3_latency", 32'(t), 32'(27));
            chk("s3_dout", 32'(dout3), 32'hC3);
            chk("s3_busy_after_done", 32'(busy3), 32'(0));
         end
      end
      if (!seen) chk("s3_timeout", 32'(0), 32'(1));
      @(negedge clk);
      ready3 = 1'b1;
      @(posedge clk);
      #1;
      chk("s3_handshake_drop", 32'(vld3), 32'(0));
      chk("s3_overrun", 32'(ovr3), 32'(0));
      @(negedge clk);
      en3 = 1'b0; ready3 = 1'b0;

      // randomized traffic
      cont_r = 1'b0;
      for (int j = 0; j < 3000; j++) begin
         if ($urandom_range(0, 15) == 0) cont_r = ~cont_r;
         step($urandom_range(0, 499) == 0, $urandom_range(0, 149) != 0,
              $urandom_range(0, 3) == 0, cont_r, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      run(30, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
